// File: rtl/hpm_event_sel_if.sv
// Bus bundle between the CSR/event sources and the HPM event-selection block.
// master = CSR unit and event sources; slave = hpm_event_sel.
interface hpm_event_sel_if #(
  parameter int XLEN       = 64,
  parameter int COUNTERS   = 32,
  parameter int NUM_EVENTS = 32
);
  logic                  CSRMWriteM;
  logic [11:0]           CSRAdrM;
  logic [XLEN-1:0]       CSRWriteValM;
  logic [1:0]            PrivilegeModeW;
  logic [NUM_EVENTS-1:0] RawEventM;
  logic [COUNTERS-1:0]   CounterOverflowM;
  logic [COUNTERS-1:0]   HPMEventM;
  logic [XLEN-1:0]       MHPMEVENTReadValM;
  logic                  IllegalMHPMEVENTM;
  logic                  LCOFIRequestM;

  modport master (
    output CSRMWriteM, CSRAdrM, CSRWriteValM, PrivilegeModeW, RawEventM, CounterOverflowM,
    input  HPMEventM, MHPMEVENTReadValM, IllegalMHPMEVENTM, LCOFIRequestM
  );

  modport slave (
    input  CSRMWriteM, CSRAdrM, CSRWriteValM, PrivilegeModeW, RawEventM, CounterOverflowM,
    output HPMEventM, MHPMEVENTReadValM, IllegalMHPMEVENTM, LCOFIRequestM
  );
endinterface

// File: rtl/hpm_event_sel.sv
// mhpmevent CSRs and per-counter event selection with registered increment strobes.
// Optional macro SSCOFPMF_EN adds OF/MINH/SINH/UINH filtering and the overflow interrupt.
module hpm_event_sel #(
  parameter int XLEN       = 64,
  parameter int COUNTERS   = 32,
  parameter int NUM_EVENTS = 32
) (
  input logic           clk,
  input logic           reset,
  hpm_event_sel_if.slave bus
);

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_U = 2'b00;
`ifdef SSCOFPMF_EN
  localparam bit SSCOF = 1'b1;
`else
  localparam bit SSCOF = 1'b0;
`endif

  logic [7:0]          evt_r [COUNTERS];
  logic [COUNTERS-1:0] of_r, minh_r, sinh_r, uinh_r;
  logic [COUNTERS-1:0] mode_inh_s, sel_s, hpm_r, wr_lo_s;
  logic [255:0]        raw_pad_s;
  logic [63:0]         wval_s, rd_s;
  logic [4:0]          adr_idx_s;
  logic                in_lo_s, in_hi_s, impl_s, illegal_s;
  logic [7:0]          wevt_s, rd_evt_s;
  logic [3:0]          rd_flags_s;
  logic                unused_wval_s;

  assign unused_wval_s = ^wval_s;

  // address decode, WARL legalisation of EVT and raw event widening
  always_comb begin
    adr_idx_s = bus.CSRAdrM[4:0];
    in_lo_s   = (bus.CSRAdrM[11:5] == 7'h19) && (adr_idx_s != 5'd0);
    in_hi_s   = (bus.CSRAdrM[11:5] == 7'h39) && (adr_idx_s != 5'd0) && (XLEN == 32);
    impl_s    = (adr_idx_s >= 5'd3) && (int'(adr_idx_s) < COUNTERS);
    wval_s    = 64'(bus.CSRWriteValM);
    wevt_s    = (int'(wval_s[7:0]) < NUM_EVENTS) ? wval_s[7:0] : 8'd0;
    raw_pad_s = 256'd0;
    raw_pad_s[NUM_EVENTS-1:0] = bus.RawEventM;
    for (int i = 0; i < COUNTERS; i++) begin
      wr_lo_s[i] = bus.CSRMWriteM && in_lo_s && impl_s && (int'(adr_idx_s) == i);
    end
  end

  // EVT field storage; counters 0..2 have no mhpmevent
  always_ff @(posedge clk) begin
    for (int i = 0; i < COUNTERS; i++) begin
      if (reset || (i < 3)) begin
        evt_r[i] <= 8'd0;
      end else if (wr_lo_s[i]) begin
        evt_r[i] <= wevt_s;
      end else begin
        evt_r[i] <= evt_r[i];
      end
    end
  end

`ifdef SSCOFPMF_EN
  logic [COUNTERS-1:0] wr_flag_s, of_prev_r;
  logic [3:0]          wflags_s;
  logic                lcofi_r;

  // flag write source: same register on RV64, mhpmeventh on RV32
  always_comb begin
    wflags_s = (XLEN == 64) ? wval_s[63:60] : wval_s[31:28];
    for (int i = 0; i < COUNTERS; i++) begin
      if (XLEN == 64) begin
        wr_flag_s[i] = wr_lo_s[i];
      end else begin
        wr_flag_s[i] = bus.CSRMWriteM && in_hi_s && impl_s && (int'(adr_idx_s) == i);
      end
      mode_inh_s[i] = (minh_r[i] && (bus.PrivilegeModeW == PRIV_M)) ||
                      (sinh_r[i] && (bus.PrivilegeModeW == PRIV_S)) ||
                      (uinh_r[i] && (bus.PrivilegeModeW == PRIV_U));
    end
  end

  // a coincident overflow always wins over a software clear of OF
  always_ff @(posedge clk) begin
    for (int i = 0; i < COUNTERS; i++) begin
      if (reset || (i < 3)) begin
        of_r[i]   <= 1'b0;
        minh_r[i] <= 1'b0;
        sinh_r[i] <= 1'b0;
        uinh_r[i] <= 1'b0;
      end else if (wr_flag_s[i]) begin
        of_r[i]   <= wflags_s[3] | bus.CounterOverflowM[i];
        minh_r[i] <= wflags_s[2];
        sinh_r[i] <= wflags_s[1];
        uinh_r[i] <= wflags_s[0];
      end else begin
        of_r[i]   <= of_r[i] | bus.CounterOverflowM[i];
        minh_r[i] <= minh_r[i];
        sinh_r[i] <= sinh_r[i];
        uinh_r[i] <= uinh_r[i];
      end
    end
  end

  // interrupt pulse on any OF rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      of_prev_r <= '0;
      lcofi_r   <= 1'b0;
    end else begin
      of_prev_r <= of_r;
      lcofi_r   <= |(of_r & ~of_prev_r);
    end
  end

  assign bus.LCOFIRequestM = lcofi_r;
`else
  logic unused_ovf_s;

  assign of_r              = '0;
  assign minh_r            = '0;
  assign sinh_r            = '0;
  assign uinh_r            = '0;
  assign mode_inh_s        = '0;
  assign unused_ovf_s      = ^bus.CounterOverflowM;
  assign bus.LCOFIRequestM = 1'b0;
`endif

  // per-counter selection of the raw event
  always_comb begin
    for (int i = 0; i < COUNTERS; i++) begin
      sel_s[i] = (i >= 3) && (evt_r[i] != 8'd0) && raw_pad_s[evt_r[i]];
    end
  end

  // one-cycle registered increment strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      hpm_r <= '0;
    end else begin
      hpm_r <= sel_s & ~mode_inh_s;
    end
  end

  // read mux: fields of the addressed counter
  always_comb begin
    rd_evt_s   = 8'd0;
    rd_flags_s = 4'd0;
    for (int i = 0; i < COUNTERS; i++) begin
      if (int'(adr_idx_s) == i) begin
        rd_evt_s   = evt_r[i];
        rd_flags_s = {of_r[i], minh_r[i], sinh_r[i], uinh_r[i]};
      end
    end
  end

  // read data and illegal-access flag; addresses outside the window are left to the top decode
  always_comb begin
    rd_s      = 64'd0;
    illegal_s = 1'b0;
    if (in_lo_s) begin
      if ((bus.PrivilegeModeW == PRIV_M) && impl_s) begin
        if (XLEN == 64) begin
          rd_s = {rd_flags_s, 52'd0, rd_evt_s};
        end else begin
          rd_s = {56'd0, rd_evt_s};
        end
      end else begin
        illegal_s = 1'b1;
      end
    end else if (in_hi_s) begin
      if (SSCOF && (bus.PrivilegeModeW == PRIV_M) && impl_s) begin
        rd_s = {32'd0, rd_flags_s, 28'd0};
      end else begin
        illegal_s = 1'b1;
      end
    end else begin
      rd_s      = 64'd0;
      illegal_s = 1'b0;
    end
  end

  assign bus.HPMEventM         = hpm_r;
  assign bus.MHPMEVENTReadValM = rd_s[XLEN-1:0];
  assign bus.IllegalMHPMEVENTM = illegal_s;

endmodule

// File: tb/tb_hpm_event_sel.sv
// Scoreboard bench for hpm_event_sel (XLEN=64, COUNTERS=8, NUM_EVENTS=32), directed plus random.
module tb_hpm_event_sel;
  localparam int XLEN = 64;
  localparam int CNT  = 8;
  localparam int NEV  = 32;

  typedef struct { logic [CNT-1:0] hpm; logic lcofi; } reg_exp_t;
  typedef struct { logic [63:0] data; logic ill; } rd_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   known = 1'b0;

  reg_exp_t q_reg[$];
  rd_exp_t  q_rd[$];

  // behavioural state of the CSRs
  bit [7:0] evt_m [CNT];
  bit       of_m [CNT], ofprev_m [CNT], minh_m [CNT], sinh_m [CNT], uinh_m [CNT];

  hpm_event_sel_if #(.XLEN(XLEN), .COUNTERS(CNT), .NUM_EVENTS(NEV)) bus ();

  hpm_event_sel #(.XLEN(XLEN), .COUNTERS(CNT), .NUM_EVENTS(NEV)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit sscof();
`ifdef SSCOFPMF_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // one stimulus cycle: record expectations from the model, then advance the model
  task automatic drive(input logic rst, input logic we, input logic [11:0] adr,
                       input logic [63:0] wv, input logic [1:0] priv,
                       input logic [31:0] raw, input logic [7:0] ovf);
    reg_exp_t re;
    rd_exp_t  rd;
    int       idx;
    bit       inh;
    @(posedge clk);
    #2;
    reset                = rst;
    bus.CSRMWriteM       = we;
    bus.CSRAdrM          = adr;
    bus.CSRWriteValM     = wv;
    bus.PrivilegeModeW   = priv;
    bus.RawEventM        = raw;
    bus.CounterOverflowM = ovf;
    idx = int'(adr[4:0]);
    rd.data = 64'd0;
    rd.ill  = 1'b0;
    if (adr >= 12'h321 && adr <= 12'h33F) begin
      if (priv == 2'd3 && idx >= 3 && idx < CNT)
        rd.data = {of_m[idx], minh_m[idx], sinh_m[idx], uinh_m[idx], 52'd0, evt_m[idx]};
      else
        rd.ill = 1'b1;
    end
    if (known) q_rd.push_back(rd);
    re.hpm   = '0;
    re.lcofi = 1'b0;
    for (int i = 3; i < CNT; i++) begin
      inh = (minh_m[i] && priv == 2'd3) || (sinh_m[i] && priv == 2'd1) || (uinh_m[i] && priv == 2'd0);
      re.hpm[i] = (evt_m[i] != 8'd0) && raw[evt_m[i]] && !inh;
      if (of_m[i] && !ofprev_m[i]) re.lcofi = 1'b1;
    end
    if (rst) begin
      re.hpm   = '0;
      re.lcofi = 1'b0;
    end
    q_reg.push_back(re);
    for (int i = 0; i < CNT; i++) begin
      if (rst) begin
        evt_m[i] = 8'd0; of_m[i] = 1'b0; ofprev_m[i] = 1'b0;
        minh_m[i] = 1'b0; sinh_m[i] = 1'b0; uinh_m[i] = 1'b0;
      end else if (i >= 3) begin
        ofprev_m[i] = of_m[i];
        if (sscof()) of_m[i] = of_m[i] | ovf[i];
        if (we && adr == 12'h320 + 12'(i)) begin
          evt_m[i] = (wv[7:0] < 8'd32) ? wv[7:0] : 8'd0;
          if (sscof()) begin
            of_m[i] = wv[63] | ovf[i];
            minh_m[i] = wv[62]; sinh_m[i] = wv[61]; uinh_m[i] = wv[60];
          end
        end
      end
    end
    if (rst) known = 1'b1;
  endtask

  // monitor: registered outputs just after the edge, read port mid-cycle
  initial begin
    reg_exp_t re;
    rd_exp_t  rd;
    forever begin
      @(posedge clk);
      #1;
      if (q_reg.size() > 0) begin
        re = q_reg.pop_front();
        check("hpm_event", 64'(bus.HPMEventM), 64'(re.hpm));
        check("lcofi", 64'(bus.LCOFIRequestM), 64'(re.lcofi));
      end
      #3;
      if (q_rd.size() > 0) begin
        rd = q_rd.pop_front();
        check("read_data", bus.MHPMEVENTReadValM, rd.data);
        check("illegal", 64'(bus.IllegalMHPMEVENTM), 64'(rd.ill));
      end
    end
  end

  initial begin
    logic [11:0] adr;
    logic [63:0] wv;
    logic [1:0]  priv;
    logic [1:0]  privs [4];
    privs = '{2'd0, 2'd1, 2'd3, 2'd3};
    bus.CSRMWriteM = 1'b0; bus.CSRAdrM = 12'd0; bus.CSRWriteValM = 64'd0;
    bus.PrivilegeModeW = 2'd3; bus.RawEventM = 32'd0; bus.CounterOverflowM = 8'd0;

    drive(1'b1, 1'b0, 12'h000, 64'd0, 2'd3, 32'd0, 8'd0);
    drive(1'b1, 1'b0, 12'h323, 64'd0, 2'd3, 32'd0, 8'd0);
    // EVT=5 then three raw pulses
    drive(1'b0, 1'b1, 12'h323, 64'd5, 2'd3, 32'd0, 8'd0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 12'h323, 64'd0, 2'd3, 32'h20, 8'd0);
    drive(1'b0, 1'b0, 12'h323, 64'd0, 2'd3, 32'd0, 8'd0);
    // WARL: out-of-range EVT stores 0
    drive(1'b0, 1'b1, 12'h324, 64'hFF, 2'd3, 32'd0, 8'd0);
    drive(1'b0, 1'b0, 12'h324, 64'd0, 2'd3, 32'h8000_0000, 8'd0);
    // illegal reads
    drive(1'b0, 1'b0, 12'h323, 64'd0, 2'd1, 32'd0, 8'd0);
    drive(1'b0, 1'b0, 12'h322, 64'd0, 2'd3, 32'd0, 8'd0);
    drive(1'b0, 1'b0, 12'h328, 64'd0, 2'd3, 32'd0, 8'd0);
    drive(1'b0, 1'b0, 12'h340, 64'd0, 2'd1, 32'd0, 8'd0);
    // shared event, and a pulse coinciding with an EVT change
    drive(1'b0, 1'b1, 12'h323, 64'd7, 2'd3, 32'd0, 8'd0);
    drive(1'b0, 1'b1, 12'h325, 64'd7, 2'd3, 32'd0, 8'd0);
    drive(1'b0, 1'b0, 12'h325, 64'd0, 2'd3, 32'h80, 8'd0);
    drive(1'b0, 1'b1, 12'h323, 64'd9, 2'd3, 32'h80, 8'd0);
    drive(1'b0, 1'b0, 12'h323, 64'd0, 2'd3, 32'h280, 8'd0);
    // mode filtering and overflow (flags only take effect with the feature built in)
    drive(1'b0, 1'b1, 12'h326, 64'h1000_0000_0000_0002, 2'd3, 32'd0, 8'd0);
    drive(1'b0, 1'b0, 12'h326, 64'd0, 2'd0, 32'h4, 8'd0);
    drive(1'b0, 1'b0, 12'h326, 64'd0, 2'd3, 32'h4, 8'd0);
    drive(1'b0, 1'b0, 12'h326, 64'd0, 2'd3, 32'd0, 8'h40);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 12'h326, 64'd0, 2'd3, 32'd0, 8'd0);
    drive(1'b0, 1'b0, 12'h326, 64'd0, 2'd3, 32'd0, 8'h40);
    drive(1'b0, 1'b0, 12'h326, 64'd0, 2'd3, 32'd0, 8'd0);
    drive(1'b0, 1'b1, 12'h326, 64'd2, 2'd3, 32'd0, 8'h40);
    drive(1'b0, 1'b0, 12'h326, 64'd0, 2'd3, 32'd0, 8'd0);
    // reset in the middle of activity
    drive(1'b0, 1'b0, 12'h325, 64'd0, 2'd3, 32'hFFFF_FFFF, 8'd0);
    drive(1'b1, 1'b0, 12'h325, 64'd0, 2'd3, 32'hFFFF_FFFF, 8'hF8);
    drive(1'b0, 1'b0, 12'h325, 64'd0, 2'd3, 32'hFFFF_FFFF, 8'd0);

    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    adr = 12'h320 + 12'($urandom_range(0, 8));
        2:       adr = 12'h320 + 12'($urandom_range(0, 31));
        default: adr = 12'($urandom);
      endcase
      wv = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) wv[7:0] = 8'($urandom_range(0, 40));
      priv = privs[$urandom_range(0, 3)];
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, adr, wv, priv,
            $urandom, ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'd0);
    end
    drive(1'b0, 1'b0, 12'h000, 64'd0, 2'd3, 32'd0, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
